// File: rtl/jk_pkg.sv
// Shared JK flip-flop encodings and the excitation helper for JK-based state machines.
package jk_pkg;

  // {j,k} pair applied to one JK cell
  typedef logic [1:0] jk_t;

  localparam jk_t JK_HOLD = 2'b00;
  localparam jk_t JK_RST  = 2'b01;
  localparam jk_t JK_SET  = 2'b10;
  localparam jk_t JK_TGL  = 2'b11;

  // Excitation that moves one cell from cur to nxt using hold/set/reset only.
  // Toggle is deliberately never produced, so the cell lands on nxt even when
  // cur was corrupted.
  function automatic jk_t jk_excite(input logic cur, input logic nxt);
    jk_t r;
    r = JK_HOLD;
    if (!cur && nxt) begin
      r = JK_SET;
    end else if (cur && !nxt) begin
      r = JK_RST;
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_sync_counter_jkff.sv
// FlipFlopJK: single JK flip-flop cell with asynchronous active-low reset.
module FlipFlopJK
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  logic q_q;

  // Classic JK behaviour: hold, reset, set, toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      case (jk_t'({j, k}))
        JK_HOLD: q_q <= q_q;
        JK_RST:  q_q <= 1'b0;
        JK_SET:  q_q <= 1'b1;
        JK_TGL:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MOD up/down counter whose state lives in a bank of
// WIDTH JK flip-flops. This level computes the target count, derives per-bit
// J/K excitation from it, and produces carry_out and the registered tc pulse.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int MOD   = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             carry_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  if (MOD < 2 || (2 ** WIDTH) < MOD) begin : g_bad_params
    $error("jk_sync_counter: MOD must be >= 2 and fit in WIDTH bits");
  end

  logic [WIDTH-1:0] nxt_d;
  logic             tc_q;
  logic [WIDTH-1:0] unused_qbar;

  // Target count: clear > load > count > hold; illegal states recover on count
  always_comb begin
    nxt_d = q;
    if (clr) begin
      nxt_d = '0;
    end else if (load) begin
      nxt_d = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up) begin
        nxt_d = (q >= MAX) ? '0 : q + 1'b1;
      end else if (q == '0 || q > MAX) begin
        nxt_d = MAX;
      end else begin
        nxt_d = q - 1'b1;
      end
    end
  end

  // Per-bit excitation steering each JK cell from q to nxt_d
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      {j_vec[i], k_vec[i]} = jk_excite(q[i], nxt_d[i]);
    end
  end

  // Wrap only from a legal terminal count; illegal states never qualify
  always_comb begin
    carry_out = en & ~clr & ~load & (up ? (q == MAX) : (q == '0));
  end

  // tc marks the cycle after a wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= carry_out;
    end
  end

  assign tc = tc_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
    FlipFlopJK u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_vec[gi]),
      .k     (k_vec[gi]),
      .q     (q[gi]),
      .q_bar (unused_qbar[gi])
    );
  end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed bench for jk_sync_counter (MOD=10, WIDTH=4).
module tb_jk_sync_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up;
  logic [3:0] q;
  logic [3:0] j_vec;
  logic [3:0] k_vec;
  logic       carry_out;
  logic       tc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  jk_sync_counter #(.MOD(10), .WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .en        (en),
    .up        (up),
    .q         (q),
    .j_vec     (j_vec),
    .k_vec     (k_vec),
    .carry_out (carry_out),
    .tc        (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_no_toggle();
    chk("no_jk_toggle", 32'(j_vec & k_vec), 32'h0);
  endtask

  // One clock edge, then settle away from the edge
  task automatic step();
    chk_no_toggle();
    @(posedge clk);
    #1;
    chk_no_toggle();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'h0; en = 1'b0; up = 1'b1;
    #12;
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_tc", 32'(tc), 32'd0);
    chk("reset_carry", 32'(carry_out), 32'd0);
    rst_n = 1'b1;

    // 1: count up 12 cycles
    en = 1'b1; up = 1'b1;
    #1;
    chk("up_carry_q0", 32'(carry_out), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("up_q", 32'(q), 32'((i + 1) % 10));
      chk("up_tc", 32'(tc), 32'(((i + 1) % 10) == 0));
      chk("up_carry", 32'(carry_out), 32'(((i + 1) % 10) == 9));
    end

    // 2: count down through the wrap
    en = 1'b0; clr = 1'b1;
    step();
    chk("clr_q", 32'(q), 32'd0);
    clr = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    chk("down_carry_q0", 32'(carry_out), 32'd1);
    step();
    chk("down_q9", 32'(q), 32'd9);
    chk("down_tc", 32'(tc), 32'd1);
    step();
    chk("down_q8", 32'(q), 32'd8);
    chk("down_tc_once", 32'(tc), 32'd0);
    step();
    chk("down_q7", 32'(q), 32'd7);

    // 3: loads, including clamp and load-over-count
    en = 1'b0; load = 1'b1; load_val = 4'hF;
    #1;
    chk("load_carry", 32'(carry_out), 32'd0);
    step();
    chk("load_clamp_q", 32'(q), 32'd9);
    chk("load_clamp_tc", 32'(tc), 32'd0);
    load_val = 4'd6; en = 1'b1; up = 1'b1;
    #1;
    chk("load_en_carry", 32'(carry_out), 32'd0);
    step();
    chk("load_en_q", 32'(q), 32'd6);
    chk("load_en_tc", 32'(tc), 32'd0);

    // 4: clr+load+en at q=9
    en = 1'b0; load_val = 4'd9;
    step();
    chk("load9_q", 32'(q), 32'd9);
    clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1;
    #1;
    chk("all_carry", 32'(carry_out), 32'd0);
    step();
    chk("all_q", 32'(q), 32'd0);
    chk("all_tc", 32'(tc), 32'd0);
    clr = 1'b0; load = 1'b0; en = 1'b0;

    // 5: illegal states planted directly in the JK bank
    #1;
    force dut.g_bank[0].u_ff.q_q = 1'b0;
    force dut.g_bank[1].u_ff.q_q = 1'b0;
    force dut.g_bank[2].u_ff.q_q = 1'b1;
    force dut.g_bank[3].u_ff.q_q = 1'b1;
    #1;
    release dut.g_bank[0].u_ff.q_q;
    release dut.g_bank[1].u_ff.q_q;
    release dut.g_bank[2].u_ff.q_q;
    release dut.g_bank[3].u_ff.q_q;
    en = 1'b1; up = 1'b1;
    #1;
    chk("illegal12_q", 32'(q), 32'd12);
    chk("illegal12_j", 32'(j_vec), 32'h0);
    chk("illegal12_k", 32'(k_vec), 32'hC);
    chk("illegal12_carry", 32'(carry_out), 32'd0);
    step();
    chk("illegal_up_q", 32'(q), 32'd0);
    chk("illegal_up_tc", 32'(tc), 32'd0);
    en = 1'b0;
    force dut.g_bank[0].u_ff.q_q = 1'b1;
    force dut.g_bank[1].u_ff.q_q = 1'b0;
    force dut.g_bank[2].u_ff.q_q = 1'b1;
    force dut.g_bank[3].u_ff.q_q = 1'b1;
    #1;
    release dut.g_bank[0].u_ff.q_q;
    release dut.g_bank[1].u_ff.q_q;
    release dut.g_bank[2].u_ff.q_q;
    release dut.g_bank[3].u_ff.q_q;
    en = 1'b1; up = 1'b0;
    #1;
    chk("illegal13_q", 32'(q), 32'd13);
    chk("illegal13_k", 32'(k_vec), 32'h4);
    chk("illegal13_carry", 32'(carry_out), 32'd0);
    step();
    chk("illegal_dn_q", 32'(q), 32'd9);
    chk("illegal_dn_tc", 32'(tc), 32'd0);

    // 6: async reset mid-count
    en = 1'b0; load = 1'b1; load_val = 4'd7;
    step();
    chk("pre_rst_q", 32'(q), 32'd7);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(q), 32'd0);
    chk("async_rst_tc", 32'(tc), 32'd0);
    rst_n = 1'b1;
    step();
    chk("resume_q1", 32'(q), 32'd1);
    step();
    chk("resume_q2", 32'(q), 32'd2);
    chk("resume_tc", 32'(tc), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
